fft_outbuffer: RTL
==================

# fft_outbuffer

Output-side frame buffer for the R2 pipeline FFT: consumes the `corefft` result stream (enable, counter, re/im), reorders each 2^NALL-point frame from bit-reversed to natural bin order in a ping-pong RAM, and presents it downstream as a valid/ready stream with bin index and end-of-frame marker. It is the counterpart of `inbuffer`: `inbuffer` frames ADC samples into the core, `fft_outbuffer` deframes core results out of it.

## Interface
- `width`, 16, bit width of each of re and im.
- `NALL`, 9, log2 of FFT points (N = 2^NALL = 512).
- `BITREV`, 1, 1: `din_cnt` is in bit-reversed bin order, write address = bit-reverse(`din_cnt`); 0: write address = `din_cnt`.

- `clk` input 1 system clock; single clock domain, all logic on rising edge.
- `areset` input 1 asynchronous, active-low reset.
- `din_en` input 1 result sample valid (from `corefft` `dout_en`).
- `din_cnt` input NALL result sample counter (from `corefft` `dout_cnt`).
- `din_re` input width signed real part.
- `din_im` input width signed imaginary part.
- `dout_valid` output 1 output sample valid.
- `dout_ready` input 1 downstream accepts sample.
- `dout_idx` output NALL natural-order bin index of current output sample.
- `dout_re` output width signed real part.
- `dout_im` output width signed imaginary part.
- `dout_last` output 1 high with bin N-1.
- `overflow` output 1 sticky: at least one input frame dropped; cleared only by reset.

## Operation
- Two banks of N entries × 2·width bits; each bank state EMPTY, FILLING, FULL, DRAINING.
- Write FSM: IDLE, WRITE. IDLE: on `din_en` && `din_cnt`==0, choose a bank: the EMPTY bank (bank 0 if both EMPTY). If none EMPTY, drop frame: set `overflow`, go to DROP (ignore `din_en` until next `din_cnt`==0 after `din_cnt`==N-1 passed). WRITE: every `din_en` writes {re,im} at mapped address; `din_cnt`==N-1 marks bank FULL, back to IDLE.
- Samples with `din_en` high and `din_cnt`≠0 while IDLE (e.g. after reset mid-frame) are discarded, no overflow.
- Gaps in `din_en` inside a frame are allowed; only `din_cnt` addresses data.
- Read FSM: IDLE, DRAIN. IDLE: if a bank is FULL (oldest first, frames never reordered), mark DRAINING, read index from 0. DRAIN: issue reads 0..N-1; after bin N-1 accepted, bank → EMPTY, back to IDLE.
- Output stage: one output register plus one-entry skid so `dout_ready` low never loses data; `dout_re/im/idx/last` held stable while `dout_valid`&&!`dout_ready`.
- Data passes bit-exact; no scaling or saturation.

## Timing
- Reset: all outputs 0, both banks EMPTY, both FSMs IDLE.
- RAM: synchronous read, 1-cycle latency.
- First-output latency: write of `din_cnt`==N-1 at edge T → `dout_valid` at edge T+2 earliest.
- Throughput: 1 sample/cycle while `dout_ready` high; a full frame drains in N cycles; back-to-back frames with no bubble between bin N-1 and next bin 0 if next bank FULL.
- Write into a bank and read from the other in the same cycle is always legal; the FILLING and DRAINING bank are never the same.
- Bank released (EMPTY) on the cycle after bin N-1 handshake; a frame starting on that same cycle may claim it.
- `areset` assert mid-frame: immediate clear; partial frames and pending outputs discarded.

## Structure
- Package `fft_buf_pkg`: bank-state and FSM state encodings, `bitrev` function parameterised by NALL.
- Sub-module `fft_dpram`: simple dual-port RAM, one write port, one synchronous read port, depth 2^(NALL+1) (bank bit as address MSB), data 2·width.

## Test plan
- Single frame, BITREV=1, din_cnt 0..511 with re=bitrev(cnt), im=-bitrev(cnt), `dout_ready`=1 → 512 outputs, dout_idx=k, re=k, im=-k, `dout_last` only at k=511, first valid 2 cycles after last write.
- Backpressure: `dout_ready` toggled pseudo-randomly (50%) over two frames → all 1024 samples in order, no duplicates, outputs stable while stalled.
- Overflow: `dout_ready`=0, three back-to-back frames → frames 1,2 stored, frame 3 dropped, `overflow`=1; releasing ready yields frames 1 then 2 only.
- Mid-frame start: reset deasserted while source at din_cnt=200 → samples 200..511 ignored, `overflow`=0, next complete frame output correctly.
- Continuous stream, `din_en` with random gaps, ready=1 → no overflow, every frame delivered intact.
- Reset during drain at bin 100 → `dout_valid`=0 next cycle, no further output until new complete frame.

Source files
------------

// File: rtl/fft_buf_pkg.sv
// Shared encodings and helpers for the FFT output frame buffer.
package fft_buf_pkg;

  localparam int unsigned BITREV_MAXW = 16;
  localparam int unsigned BITREV_IW   = $clog2(BITREV_MAXW);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Reverse the low n bits of x; bits at and above n come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] x,
                                                    input int unsigned n);
    logic [BITREV_MAXW-1:0] r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAXW; i++) begin
      if (i < n) begin
        j = n - 1 - i;
        r[i] = x[j[BITREV_IW-1:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module fft_dpram
  import fft_buf_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_outbuffer.sv
// Ping-pong output buffer: bit-reversed FFT results in, natural-order valid/ready stream out.
module fft_outbuffer
  import fft_buf_pkg::*;
#(
  parameter int unsigned width  = 16,
  parameter int unsigned NALL   = 9,
  parameter bit          BITREV = 1'b1
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    din_en,
  input  logic [NALL-1:0]         din_cnt,
  input  logic signed [width-1:0] din_re,
  input  logic signed [width-1:0] din_im,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [NALL-1:0]         dout_idx,
  output logic signed [width-1:0] dout_re,
  output logic signed [width-1:0] dout_im,
  output logic                    dout_last,
  output logic                    overflow
);

  localparam int unsigned N  = 1 << NALL;
  localparam int unsigned AW = NALL + 1;
  localparam int unsigned DW = 2 * width;
  localparam logic [NALL-1:0] LAST_IDX = NALL'(N - 1);

  // Bank bookkeeping
  bank_state_t bank_st [2];
  bank_state_t bank_st_n [2];
  logic        older, older_n;

  // Write side
  wr_state_t       wr_state, wr_state_n;
  logic            wr_bank, wr_bank_n;
  logic            overflow_n;
  logic            we_c, claim_c, full_c;
  logic [NALL-1:0] wmap_c;
  logic            cnt_first_c, cnt_last_c;

  // Read side
  rd_state_t       rd_state, rd_state_n;
  logic            rd_bank, rd_bank_n;
  logic [NALL-1:0] rd_idx, rd_idx_n;
  logic            issue_c, pick_c, issue_ok_c;
  logic [NALL-1:0] issue_idx_c;
  logic [1:0]      occ_c;

  // RAM output stage, skid and output register bookkeeping
  logic [DW-1:0]           ram_q;
  logic signed [width-1:0] ram_re_c, ram_im_c;
  logic                    rv, rv_last, rv_bank;
  logic [NALL-1:0]         rv_idx;
  logic                    sv, s_last, s_bank;
  logic [NALL-1:0]         s_idx;
  logic signed [width-1:0] s_re, s_im;
  logic                    out_bank;
  logic                    take_c, hs_last_c;

  assign cnt_first_c = (din_cnt == '0);
  assign cnt_last_c  = (din_cnt == LAST_IDX);
  assign wmap_c      = BITREV ? NALL'(bitrev(BITREV_MAXW'(din_cnt), NALL)) : din_cnt;

  assign ram_re_c  = ram_q[DW-1:width];
  assign ram_im_c  = ram_q[width-1:0];
  assign take_c    = dout_valid && dout_ready;
  assign hs_last_c = take_c && dout_last;

  // Slots that will still be occupied after this edge; a read may be issued only
  // if its data is guaranteed a place in the output register or skid.
  assign occ_c      = 2'(dout_valid) + 2'(sv) + 2'(rv) - 2'(take_c);
  assign issue_ok_c = (occ_c <= 2'd1);

  fft_dpram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr ({wr_bank_n, wmap_c}),
    .wdata ({din_re, din_im}),
    .re    (issue_c),
    .raddr ({rd_bank_n, issue_idx_c}),
    .rdata (ram_q)
  );

  // Write FSM: claim an empty bank at bin 0, fill it, or drop the whole frame.
  always_comb begin
    wr_state_n = wr_state;
    wr_bank_n  = wr_bank;
    overflow_n = overflow;
    we_c       = 1'b0;
    claim_c    = 1'b0;
    full_c     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (din_en && cnt_first_c) begin
          if (bank_st[0] == BANK_EMPTY) begin
            wr_bank_n  = 1'b0;
            claim_c    = 1'b1;
            we_c       = 1'b1;
            wr_state_n = WR_WRITE;
          end else if (bank_st[1] == BANK_EMPTY) begin
            wr_bank_n  = 1'b1;
            claim_c    = 1'b1;
            we_c       = 1'b1;
            wr_state_n = WR_WRITE;
          end else begin
            overflow_n = 1'b1;
            wr_state_n = WR_DROP;
          end
        end
      end
      WR_WRITE: begin
        if (din_en) begin
          we_c = 1'b1;
          if (cnt_last_c) begin
            full_c     = 1'b1;
            wr_state_n = WR_IDLE;
          end
        end
      end
      WR_DROP: begin
        if (din_en && cnt_last_c) wr_state_n = WR_IDLE;
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // Read FSM: pick the oldest full bank and issue bins 0..N-1 as space allows.
  always_comb begin
    rd_state_n  = rd_state;
    rd_bank_n   = rd_bank;
    rd_idx_n    = rd_idx;
    issue_c     = 1'b0;
    issue_idx_c = rd_idx;
    pick_c      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (issue_ok_c && (bank_st[older] == BANK_FULL || bank_st[~older] == BANK_FULL)) begin
          pick_c      = 1'b1;
          rd_bank_n   = (bank_st[older] == BANK_FULL) ? older : ~older;
          issue_c     = 1'b1;
          issue_idx_c = '0;
          rd_idx_n    = NALL'(1);
          rd_state_n  = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (issue_ok_c) begin
          issue_c  = 1'b1;
          rd_idx_n = rd_idx + NALL'(1);
          if (rd_idx == LAST_IDX) rd_state_n = RD_IDLE;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  // Bank state transitions; each bank sees at most one event per cycle.
  always_comb begin
    bank_st_n = bank_st;
    older_n   = older;
    if (claim_c) bank_st_n[wr_bank_n] = BANK_FILLING;
    if (full_c) begin
      bank_st_n[wr_bank] = BANK_FULL;
      if (bank_st[~wr_bank] != BANK_FULL) older_n = wr_bank;
    end
    if (pick_c) bank_st_n[rd_bank_n] = BANK_DRAINING;
    if (hs_last_c) bank_st_n[out_bank] = BANK_EMPTY;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_state   <= WR_IDLE;
      wr_bank    <= 1'b0;
      overflow   <= 1'b0;
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      older      <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wr_bank  <= wr_bank_n;
      overflow <= overflow_n;
      rd_state <= rd_state_n;
      rd_bank  <= rd_bank_n;
      rd_idx   <= rd_idx_n;
      bank_st  <= bank_st_n;
      older    <= older_n;
    end
  end

  // Sideband that travels alongside the RAM read data.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rv      <= 1'b0;
      rv_idx  <= '0;
      rv_last <= 1'b0;
      rv_bank <= 1'b0;
    end else begin
      rv <= issue_c;
      if (issue_c) begin
        rv_idx  <= issue_idx_c;
        rv_last <= (issue_idx_c == LAST_IDX);
        rv_bank <= rd_bank_n;
      end
    end
  end

  // Output register plus one-entry skid; order is output, skid, RAM.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      dout_valid <= 1'b0;
      dout_idx   <= '0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_last  <= 1'b0;
      out_bank   <= 1'b0;
      sv         <= 1'b0;
      s_idx      <= '0;
      s_re       <= '0;
      s_im       <= '0;
      s_last     <= 1'b0;
      s_bank     <= 1'b0;
    end else if (!dout_valid || dout_ready) begin
      if (sv) begin
        dout_valid <= 1'b1;
        dout_idx   <= s_idx;
        dout_re    <= s_re;
        dout_im    <= s_im;
        dout_last  <= s_last;
        out_bank   <= s_bank;
        sv         <= rv;
        if (rv) begin
          s_idx  <= rv_idx;
          s_re   <= ram_re_c;
          s_im   <= ram_im_c;
          s_last <= rv_last;
          s_bank <= rv_bank;
        end
      end else begin
        dout_valid <= rv;
        if (rv) begin
          dout_idx  <= rv_idx;
          dout_re   <= ram_re_c;
          dout_im   <= ram_im_c;
          dout_last <= rv_last;
          out_bank  <= rv_bank;
        end
      end
    end else if (rv) begin
      sv     <= 1'b1;
      s_idx  <= rv_idx;
      s_re   <= ram_re_c;
      s_im   <= ram_im_c;
      s_last <= rv_last;
      s_bank <= rv_bank;
    end
  end

endmodule
